// File: rtl/conv_bram_1d_img_loader_pkg.sv
// Shared types and helpers for the 1-D BRAM convolution image loader.
package conv_bram_1d_img_loader_pkg;

  // Loader phases: filling the image memories, starting the engine, waiting for it.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Counter/address width for n distinct values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_bram_1d_img_loader_if.sv
// Valid/ready image element stream feeding the loader.
interface conv_bram_1d_img_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_val;
  logic                  s_rdy;
  logic                  s_last;

  modport master (output s_data, output s_val, output s_last, input s_rdy);
  modport slave  (input s_data, input s_val, input s_last, output s_rdy);
endinterface

// File: rtl/conv_bram_1d_wrport.sv
// Registered write port for one channel BRAM: address/data load only when
// the channel is selected, write enable pulses for exactly that cycle.
module conv_bram_1d_wrport #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] wraddr,
  output logic          wren,
  output logic [DW-1:0] wrdata
);
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          wren_q;

  // Capture the beat for this channel; unselected channels keep their last address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      wren_q <= sel;
      if (sel) begin
        addr_q <= addr;
        data_q <= data;
      end
    end
  end

  assign wraddr = addr_q;
  assign wrdata = data_q;
  assign wren   = wren_q;
endmodule

// File: rtl/conv_bram_1d_img_loader.sv
// Loads a column-major image stream into per-channel BRAMs, then starts the
// convolution engine and holds off new data until the engine is idle again.
module conv_bram_1d_img_loader
  import conv_bram_1d_img_loader_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int IMG_W              = 32,
  parameter int IMG_D              = 4,
  parameter int IMG_RAM_ADDR_WIDTH = cnt_width(IMG_W)
) (
  input  logic                                clk,
  input  logic                                reset,
  conv_bram_1d_img_loader_if.slave            s,
  output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0] img_wraddr,
  output logic [DATA_WIDTH*IMG_D-1:0]         img_wrdata,
  output logic [IMG_D-1:0]                    img_wren,
  output logic                                conv_val,
  input  logic                                conv_rdy,
  output logic                                frame_err
);
  localparam int DCNT_W = cnt_width(IMG_D);
  localparam int AW     = IMG_RAM_ADDR_WIDTH;
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(IMG_D - 1);
  localparam logic [AW-1:0]     W_LAST = AW'(IMG_W - 1);

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   d_cnt_q, d_cnt_d;
  logic [AW-1:0]       w_cnt_q, w_cnt_d;
  logic                s_rdy_q;
  logic                conv_val_q, conv_val_d;
  logic                frame_err_q, frame_err_d;
  logic                rdy_low_q, rdy_low_d;
  logic                accept;
  logic                last_beat;
  logic                handshake;
  logic [IMG_D-1:0]    sel;

  // s_rdy is registered and high only while in LOAD, so acceptance implies LOAD.
  assign accept    = s.s_val & s_rdy_q;
  assign last_beat = (d_cnt_q == D_LAST) && (w_cnt_q == W_LAST);
  assign handshake = conv_val_q & conv_rdy;

  // Next-state, counter and flag logic.
  always_comb begin
    state_d     = state_q;
    d_cnt_d     = d_cnt_q;
    w_cnt_d     = w_cnt_q;
    conv_val_d  = 1'b0;
    frame_err_d = frame_err_q;
    rdy_low_d   = rdy_low_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (d_cnt_q == D_LAST) begin
            d_cnt_d = '0;
            if (w_cnt_q == W_LAST) begin
              w_cnt_d = '0;
              state_d = ST_START;
            end else begin
              w_cnt_d = w_cnt_q + 1'b1;
            end
          end else begin
            d_cnt_d = d_cnt_q + 1'b1;
          end
          // Boundary is set by the counters; s_last only flags a misframed producer.
          if (s.s_last != last_beat) frame_err_d = 1'b1;
        end
      end
      ST_START: begin
        // Registered conv_val stays low in the first START cycle, which is
        // the cycle carrying the final BRAM write.
        conv_val_d = ~handshake;
        rdy_low_d  = 1'b0;
        if (handshake) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Engine is idle again only after it has been seen busy at least once.
        if (!conv_rdy) rdy_low_d = 1'b1;
        else if (rdy_low_q) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      d_cnt_q     <= '0;
      w_cnt_q     <= '0;
      s_rdy_q     <= 1'b0;
      conv_val_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rdy_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_cnt_q     <= d_cnt_d;
      w_cnt_q     <= w_cnt_d;
      s_rdy_q     <= (state_d == ST_LOAD);
      conv_val_q  <= conv_val_d;
      frame_err_q <= frame_err_d;
      rdy_low_q   <= rdy_low_d;
    end
  end

  assign s.s_rdy   = s_rdy_q;
  assign conv_val  = conv_val_q;
  assign frame_err = frame_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < IMG_D; gi++) begin : g_wrport
      assign sel[gi] = accept && (d_cnt_q == DCNT_W'(gi));
      conv_bram_1d_wrport #(
        .AW (AW),
        .DW (DATA_WIDTH)
      ) u_wrport (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel[gi]),
        .addr   (w_cnt_q),
        .data   (s.s_data),
        .wraddr (img_wraddr[gi*AW +: AW]),
        .wren   (img_wren[gi]),
        .wrdata (img_wrdata[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_conv_bram_1d_img_loader.sv
// Self-checking bench for conv_bram_1d_img_loader.
module tb_conv_bram_1d_img_loader;
  localparam int DW = 8;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AW = 5;
  localparam int N  = W * D;

  logic clk = 1'b0;
  logic reset;
  logic [AW*D-1:0] img_wraddr;
  logic [DW*D-1:0] img_wrdata;
  logic [D-1:0]    img_wren;
  logic            conv_val;
  logic            conv_rdy;
  logic            frame_err;

  always #5 clk = ~clk;

  conv_bram_1d_img_loader_if #(.DATA_WIDTH(DW)) s_if ();

  conv_bram_1d_img_loader #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_D      (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s_if),
    .img_wraddr (img_wraddr),
    .img_wrdata (img_wrdata),
    .img_wren   (img_wren),
    .conv_val   (conv_val),
    .conv_rdy   (conv_rdy),
    .frame_err  (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  bit fe_model = 1'b0;

  logic [DW-1:0] dut_mem [D][W];
  logic [DW-1:0] ref_mem [D][W];

  typedef struct packed {
    logic conv_rdy;
    logic s_val;
    logic exp_conv_val;
    logic exp_s_rdy;
    logic [D-1:0] exp_wren;
  } vec_t;
  vec_t tbl [8];

  // BRAM model and engine-start counter, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < D; d++)
      if (img_wren[d] === 1'b1) dut_mem[d][img_wraddr[d*AW +: AW]] = img_wrdata[d*DW +: DW];
    if (conv_val === 1'b1 && conv_rdy === 1'b1) hs_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int d = 0; d < D; d++)
      for (int w = 0; w < W; w++)
        if (dut_mem[d][w] !== ref_mem[d][w]) n++;
    return n;
  endfunction

  task automatic wait_rdy();
    int cyc = 0;
    while (s_if.s_rdy !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("s_rdy_wait", 64'(cyc < 20), 1);
  endtask

  // Back-to-back beats with per-beat write-port timing checks.
  task automatic load_b2b(input int nbeats, input int err_beat, input int off);
    for (int k = 0; k < nbeats; k++) begin
      int ch;
      logic [DW-1:0] dv;
      logic [D-1:0] ew;
      ch = k % D;
      dv = DW'(k + off);
      s_if.s_val  = 1'b1;
      s_if.s_data = dv;
      s_if.s_last = (k == N - 1) || (k == err_beat);
      if (s_if.s_last != (k == N - 1)) fe_model = 1'b1;
      ref_mem[ch][k / D] = dv;
      step();
      ew = '0;
      ew[ch] = 1'b1;
      chk($sformatf("wren[%0d]", k), img_wren, ew);
      chk($sformatf("wraddr[%0d]", k), img_wraddr[ch*AW +: AW], k / D);
      chk($sformatf("wrdata[%0d]", k), img_wrdata[ch*DW +: DW], dv);
      chk($sformatf("s_rdy[%0d]", k), s_if.s_rdy, (k != N - 1));
      chk($sformatf("frame_err[%0d]", k), frame_err, fe_model);
    end
    s_if.s_val  = 1'b0;
    s_if.s_last = 1'b0;
  endtask

  // Randomly gapped load of one full image into the reference memory.
  task automatic load_rand();
    int k = 0;
    int cyc = 0;
    while (k < N && cyc < 4000) begin
      s_if.s_val  = ($urandom_range(0, 1) == 1);
      s_if.s_data = DW'($urandom);
      s_if.s_last = (k == N - 1);
      if (s_if.s_val && s_if.s_rdy === 1'b1) begin
        ref_mem[k % D][k / D] = s_if.s_data;
        k++;
      end
      step();
      cyc++;
    end
    s_if.s_val  = 1'b0;
    s_if.s_last = 1'b0;
    chk("load_rand_beats", k, N);
  endtask

  // Idle engine: accept the start, stay busy, then become ready again.
  task automatic engine_run(input int busy);
    int cyc = 0;
    conv_rdy = 1'b1;
    while (conv_val !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("conv_val_timeout", 64'(cyc < 100), 1);
    step();
    chk("conv_val_drop", conv_val, 0);
    conv_rdy = 1'b0;
    repeat (busy) begin
      step();
      chk("s_rdy_busy", s_if.s_rdy, 0);
    end
    conv_rdy = 1'b1;
    step();
    chk("s_rdy_after_engine", s_if.s_rdy, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    tbl[0] = '{conv_rdy: 1'b0, s_val: 1'b1, exp_conv_val: 1'b1, exp_s_rdy: 1'b0, exp_wren: '0};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{conv_rdy: 1'b0, s_val: 1'b1, exp_conv_val: 1'b1, exp_s_rdy: 1'b0, exp_wren: '0};
    tbl[6] = '{conv_rdy: 1'b1, s_val: 1'b1, exp_conv_val: 1'b0, exp_s_rdy: 1'b0, exp_wren: '0};
    tbl[7] = '{conv_rdy: 1'b0, s_val: 1'b1, exp_conv_val: 1'b0, exp_s_rdy: 1'b0, exp_wren: '0};
    for (int d = 0; d < D; d++)
      for (int w = 0; w < W; w++) begin
        dut_mem[d][w] = '0;
        ref_mem[d][w] = '0;
      end

    // Reset state
    reset = 1'b1;
    conv_rdy = 1'b0;
    s_if.s_val = 1'b0;
    s_if.s_data = '0;
    s_if.s_last = 1'b0;
    repeat (3) step();
    chk("rst_s_rdy", s_if.s_rdy, 0);
    chk("rst_conv_val", conv_val, 0);
    chk("rst_wren", img_wren, 0);
    chk("rst_wraddr", img_wraddr, 0);
    chk("rst_wrdata", img_wrdata, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    wait_rdy();

    // Image 1: back-to-back, data = beat index
    load_b2b(N, -1, 0);
    chk("conv_val_at_final_write", conv_val, 0);

    // START with engine busy, then handshake and busy period
    hs0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      conv_rdy = tbl[i].conv_rdy;
      s_if.s_val = tbl[i].s_val;
      s_if.s_data = 8'hEE;
      step();
      chk($sformatf("tbl_conv_val[%0d]", i), conv_val, tbl[i].exp_conv_val);
      chk($sformatf("tbl_s_rdy[%0d]", i), s_if.s_rdy, tbl[i].exp_s_rdy);
      chk($sformatf("tbl_wren[%0d]", i), img_wren, tbl[i].exp_wren);
    end
    chk("hs_img1", hs_cnt - hs0, 1);
    for (int i = 0; i < 200; i++) begin
      conv_rdy = 1'b0;
      s_if.s_val = 1'b1;
      step();
      chk("wait_wren", img_wren, 0);
      chk("wait_s_rdy", s_if.s_rdy, 0);
      chk("wait_conv_val", conv_val, 0);
    end
    conv_rdy = 1'b1;
    step();
    s_if.s_val = 1'b0;
    chk("s_rdy_return", s_if.s_rdy, 1);
    chk("mem_img1", mem_diff(), 0);
    chk("frame_err_img1", frame_err, 0);

    // Two randomly gapped images
    hs0 = hs_cnt;
    for (int img = 0; img < 2; img++) begin
      load_rand();
      engine_run($urandom_range(1, 20));
      chk($sformatf("mem_rand%0d", img), mem_diff(), 0);
    end
    chk("hs_rand", hs_cnt - hs0, 2);
    chk("frame_err_rand", frame_err, 0);

    // Misplaced s_last on beat 60
    load_b2b(N, 60, 37);
    engine_run(3);
    chk("mem_err_img", mem_diff(), 0);
    chk("frame_err_sticky", frame_err, 1);

    // Reset after beat 70
    load_b2b(71, -1, 90);
    reset = 1'b1;
    fe_model = 1'b0;
    step();
    step();
    chk("rst2_s_rdy", s_if.s_rdy, 0);
    chk("rst2_conv_val", conv_val, 0);
    chk("rst2_wren", img_wren, 0);
    chk("rst2_wraddr", img_wraddr, 0);
    chk("rst2_wrdata", img_wrdata, 0);
    chk("rst2_frame_err", frame_err, 0);
    reset = 1'b0;
    conv_rdy = 1'b1;
    hs0 = hs_cnt;
    repeat (5) begin
      step();
      chk("abort_no_start", conv_val, 0);
    end
    wait_rdy();
    load_b2b(N, -1, 200);
    engine_run(4);
    chk("hs_after_abort", hs_cnt - hs0, 1);
    chk("mem_after_abort", mem_diff(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
